ili_spi_slave_rx: RTL

//  SPI mode-0 slave receiver modelling the ILI9341 panel end of the 4-wire display link (sclk, mosi, dc, cs).

---
 rtl/ili_spi_slave_rx.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ili_spi_slave_rx.sv
// ili_spi_slave_rx
// -----------------------------------------------------------------------------
// SPI mode-0 slave receiver standing in for the ILI9341 end of the 4-wire
// display link. The pins are oversampled in the clk domain. Bytes are
// assembled MSB-first and tagged command (dc=0) or data (dc=1). They are then
// buffered in a show-ahead FIFO. A host-supplied response byte is shifted out
// on miso, changing on falling sclk edges so the master can sample it on
// rising edges.
//
// Ports
//   clk          system clock, at least 4x the sclk frequency
//   rst          asynchronous active-low reset
//   i_sclk       SPI clock from the master, idle low
//   i_cs         chip select, active low
//   i_mosi       serial data from the master
//   i_dc         data/command select (0 = command)
//   i_tx_data    response byte, captured at the start of each byte
//   o_miso       serial response to the master
//   o_data       FIFO head byte (0 when empty)
//   o_is_cmd     FIFO head tag, 1 = byte was received with dc=0
//   o_valid      FIFO not empty
//   i_ready      consumer pops the head when o_valid && i_ready
//   o_overflow   sticky flag: a byte was dropped because the FIFO was full
//   o_frame_err  one-cycle pulse: cs was deasserted in the middle of a byte
//   i_clr_err    clears o_overflow (a new overflow in the same cycle wins)
// -----------------------------------------------------------------------------
module ili_spi_slave_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sclk,
  input  logic       i_cs,
  input  logic       i_mosi,
  input  logic       i_dc,
  input  logic [7:0] i_tx_data,
  output logic       o_miso,
  output logic [7:0] o_data,
  output logic       o_is_cmd,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_overflow,
  output logic       o_frame_err,
  input  logic       i_clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_dc_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  logic w_sclk_s, w_cs_s, w_mosi_s, w_dc_s;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_dc_s   = r_dc_sync[SYNC_STAGES-1];

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_dc_sync   <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], i_dc};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive/transmit FSM
  // ---------------------------------------------------------------------------
  state_t     r_state, w_state_next;
  logic [7:0] r_shift_rx, w_shift_rx_next;
  logic [7:0] r_shift_tx, w_shift_tx_next;
  logic [2:0] r_bit_cnt, w_bit_cnt_next;
  logic       r_skip_fall, w_skip_fall_next;
  logic       r_frame_err, w_frame_err_next;
  logic       w_push;
  logic [8:0] w_push_entry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_shift_rx  <= '0;
      r_shift_tx  <= '0;
      r_bit_cnt   <= '0;
      r_skip_fall <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift_rx  <= w_shift_rx_next;
      r_shift_tx  <= w_shift_tx_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_skip_fall <= w_skip_fall_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_shift_rx_next  = r_shift_rx;
    w_shift_tx_next  = r_shift_tx;
    w_bit_cnt_next   = r_bit_cnt;
    w_skip_fall_next = r_skip_fall;
    w_frame_err_next = 1'b0;
    w_push           = 1'b0;
    // Entry layout {is_cmd, byte}; the byte includes the bit arriving now.
    w_push_entry     = {~w_dc_s, r_shift_rx[6:0], w_mosi_s};

    unique case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_shift_tx_next  = i_tx_data;
          w_bit_cnt_next   = '0;
          w_skip_fall_next = 1'b0;
          w_state_next     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_cs_s) begin
          // cs released: a nonzero counter means a partial byte is thrown away.
          w_frame_err_next = (r_bit_cnt != 3'd0);
          w_bit_cnt_next   = '0;
          w_state_next     = ST_IDLE;
        end else if (w_sclk_rise) begin
          w_shift_rx_next = {r_shift_rx[6:0], w_mosi_s};
          w_bit_cnt_next  = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_push           = 1'b1;
            w_shift_tx_next  = i_tx_data;
            // The falling edge that closes this byte must not shift the
            // freshly loaded response, otherwise its bit 7 would be lost
            // before the master samples it on the next rising edge.
            w_skip_fall_next = 1'b1;
          end
        end else if (w_sclk_fall) begin
          if (r_skip_fall) begin
            w_skip_fall_next = 1'b0;
          end else begin
            w_shift_tx_next = {r_shift_tx[6:0], 1'b0};
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_miso      = (r_state == ST_SHIFT) & r_shift_tx[7];
  assign o_frame_err = r_frame_err;

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------------
  logic [8:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic        r_overflow;
  logic        w_empty, w_full, w_pop, w_wr_en;
  logic [8:0]  w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr_en = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end else if (i_clr_err) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Head is masked while empty so stale RAM contents never reach the outputs.
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign o_valid    = ~w_empty;
  assign o_data     = o_valid ? w_head[7:0] : 8'h00;
  assign o_is_cmd   = o_valid & w_head[8];
  assign o_overflow = r_overflow;

endmodule
